// File: rtl/param_fifo_if.sv
// param_fifo_if: handshake bundle between a producer/consumer pair and param_fifo.
// master = the logic driving writes/reads, slave = the FIFO itself.
interface param_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  fifo_write;
  logic                  fifo_read;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_almost_full;
  logic                  fifo_almost_empty;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_overflow;
  logic                  fifo_underflow;

  modport master (
    output fifo_data_in, fifo_write, fifo_read, clr_err,
    input  fifo_data_out, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_count, fifo_overflow, fifo_underflow
  );

  modport slave (
    input  fifo_data_in, fifo_write, fifo_read, clr_err,
    output fifo_data_out, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_count, fifo_overflow, fifo_underflow
  );
endinterface

// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional macro PARAM_FIFO_FWFT_EN selects first-word-fall-through reads;
// otherwise read data is registered and appears one cycle after the read.
module param_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic          clk,
  input logic          rst_,
  param_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  overflow;
  logic                  underflow;

  // Full/empty come from the registered count, so no input reaches an output
  // combinationally; pointer equality alone could not tell them apart.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Accept decisions on pre-edge state; a full FIFO still takes a write
  // when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok = bus.fifo_read && !empty;
    wr_ok = bus.fifo_write && (!full || rd_ok);
  end

  // Pointers, occupancy and sticky error flags; a new error beats clr_err.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= (bus.fifo_write && !wr_ok) || (overflow  && !bus.clr_err);
      underflow <= (bus.fifo_read  && !rd_ok) || (underflow && !bus.clr_err);
    end
  end

  // Storage array is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_ && wr_ok) mem[wr_ptr] <= bus.fifo_data_in;
  end

`ifdef PARAM_FIFO_FWFT_EN
  // Head word is visible as soon as it is stored; zero when nothing is held.
  assign bus.fifo_data_out = empty ? '0 : mem[rd_ptr];
`else
  logic [DATA_WIDTH-1:0] rd_data;

  // Registered read: the popped word appears one cycle after the read edge
  // and holds until the next accepted read.
  always_ff @(posedge clk) begin
    if (!rst_)      rd_data <= '0;
    else if (rd_ok) rd_data <= mem[rd_ptr];
  end

  assign bus.fifo_data_out = rd_data;
`endif

  assign bus.fifo_full         = full;
  assign bus.fifo_empty        = empty;
  assign bus.fifo_almost_full  = (count >= AF_CNT);
  assign bus.fifo_almost_empty = (count <= AE_CNT);
  assign bus.fifo_count        = count;
  assign bus.fifo_overflow     = overflow;
  assign bus.fifo_underflow    = underflow;
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: vector table plus hand sequences for param_fifo (DEPTH=16,
// 16-bit data); read data is checked against a queue scoreboard.
module tb_param_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFL   = DEPTH - 2;
  localparam int AEL   = 2;

  logic clk = 1'b0;
  logic rst_;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] m_dout;

  typedef struct {
    bit            w;
    bit            r;
    bit            c;
    logic [DW-1:0] d;
    int            cnt;
    bit            ovf;
    bit            unf;
  } vec_t;

  vec_t vecs [10];

  param_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  param_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int e_cnt, input bit e_ovf, input bit e_unf);
    logic [DW-1:0] e_data;
    check({tag, "/count"}, int'(bus.fifo_count), e_cnt);
    check({tag, "/flags"},
          int'({bus.fifo_full, bus.fifo_empty, bus.fifo_almost_full, bus.fifo_almost_empty}),
          int'({e_cnt == DEPTH, e_cnt == 0, e_cnt >= AFL, e_cnt <= AEL}));
    check({tag, "/err"}, int'({bus.fifo_overflow, bus.fifo_underflow}), int'({e_ovf, e_unf}));
`ifdef PARAM_FIFO_FWFT_EN
    e_data = (sb_q.size() != 0) ? sb_q[0] : '0;
`else
    e_data = m_dout;
`endif
    check({tag, "/data"}, int'(bus.fifo_data_out), int'(e_data));
  endtask

  // One clock of stimulus; the scoreboard decides acceptance from its own occupancy.
  task automatic apply(input string tag, input bit w, input bit r, input bit c,
                       input logic [DW-1:0] d, input int e_cnt, input bit e_ovf, input bit e_unf);
    bit rd_ok, wr_ok;
    rd_ok = r && (sb_q.size() != 0);
    wr_ok = w && (sb_q.size() != DEPTH || rd_ok);
    if (rd_ok) m_dout = sb_q.pop_front();
    if (wr_ok) sb_q.push_back(d);
    bus.fifo_write   = w;
    bus.fifo_read    = r;
    bus.clr_err      = c;
    bus.fifo_data_in = d;
    @(posedge clk);
    #1;
    bus.fifo_write = 1'b0;
    bus.fifo_read  = 1'b0;
    bus.clr_err    = 1'b0;
    check_state(tag, e_cnt, e_ovf, e_unf);
  endtask

  // Reset with a write still requested: reset must win.
  task automatic do_reset(input string tag);
    rst_             = 1'b0;
    bus.fifo_write   = 1'b1;
    bus.fifo_read    = 1'b0;
    bus.clr_err      = 1'b0;
    bus.fifo_data_in = 16'h0777;
    @(posedge clk);
    #1;
    rst_           = 1'b1;
    bus.fifo_write = 1'b0;
    sb_q.delete();
    m_dout = '0;
    check_state(tag, 0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0001, 1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0002, 2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0003, 3, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h0055, 1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0};

    rst_             = 1'b0;
    bus.fifo_write   = 1'b0;
    bus.fifo_read    = 1'b0;
    bus.clr_err      = 1'b0;
    bus.fifo_data_in = '0;
    m_dout           = '0;
    @(posedge clk);
    #1;
    do_reset("reset");
    apply("idle", 1'b0, 1'b0, 1'b0, 16'h0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++)
      apply($sformatf("vec%0d", i), vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].d,
            vecs[i].cnt, vecs[i].ovf, vecs[i].unf);

    for (int i = 0; i < DEPTH; i++)
      apply($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b0, DW'(i), i + 1, 1'b0, 1'b0);
    apply("overflow", 1'b1, 1'b0, 1'b0, 16'h0099, DEPTH, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      apply($sformatf("drain%0d", i), 1'b0, 1'b1, 1'b0, 16'h0, DEPTH - 1 - i, 1'b1, 1'b0);

    for (int i = 0; i < DEPTH; i++)
      apply($sformatf("refill%0d", i), 1'b1, 1'b0, 1'b0, DW'(16'h0100 + i), i + 1, 1'b1, 1'b0);
    apply("clr_ovf", 1'b0, 1'b0, 1'b1, 16'h0, DEPTH, 1'b0, 1'b0);
    apply("full_rw", 1'b1, 1'b1, 1'b0, 16'hAAAA, DEPTH, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      apply($sformatf("drain2_%0d", i), 1'b0, 1'b1, 1'b0, 16'h0, DEPTH - 1 - i, 1'b0, 1'b0);
    check("last_word", int'(m_dout), 16'hAAAA);
    apply("underflow", 1'b0, 1'b1, 1'b0, 16'h0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 7; i++)
      apply($sformatf("pre_rst%0d", i), 1'b1, 1'b0, 1'b0, DW'(16'h0200 + i), i + 1, 1'b0, 1'b1);
    do_reset("mid_reset");

    apply("single_wr", 1'b1, 1'b0, 1'b0, 16'h1234, 1, 1'b0, 1'b0);
    apply("single_rd", 1'b0, 1'b1, 1'b0, 16'h0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
